// File: rtl/ex_hazard_ctrl.sv
// Hazard/sequencing controller around EX: load-use interlock, redirect flush,
// multi-cycle EX hold. Define STALL_PERF_CNT_EN to add stall/flush counters.
module ex_hazard_ctrl #(
  parameter int RF_ADDRESS = 5,
  parameter int MD_LAT     = 4,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [RF_ADDRESS-1:0] id_rs1,
  input  logic [RF_ADDRESS-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [RF_ADDRESS-1:0] idex_rd,
  input  logic                  idex_memread,
  input  logic                  ex_redirect,
  input  logic                  ex_md_op,
  output logic                  pc_write,
  output logic                  ifid_write,
  output logic                  idex_write,
  output logic                  idex_bubble,
  output logic                  ifid_flush,
  output logic                  exmem_bubble,
  output logic                  md_busy,
  output logic                  md_done
`ifdef STALL_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      flush_count
`endif
);

  localparam int CW = $clog2(MD_LAT + 1);

  localparam logic [0:0] RUN     = 1'b0;
  localparam logic [0:0] MD_BUSY = 1'b1;

  // Entry cycle counts as the first EX cycle, and the final cycle is the one
  // seen with the counter at zero, hence MD_LAT-2.
  localparam logic [CW-1:0] MD_LOAD = (MD_LAT > 1) ? CW'(MD_LAT - 2) : '0;

  logic [0:0]    state;
  logic [0:0]    state_nxt;
  logic [CW-1:0] md_cnt;
  logic [CW-1:0] md_cnt_nxt;
  logic          load_use;

  always_comb begin
    load_use = idex_memread && (idex_rd != '0) &&
               ((id_uses_rs1 && (idex_rd == id_rs1)) ||
                (id_uses_rs2 && (idex_rd == id_rs2)));
  end

  always_comb begin
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    idex_write   = 1'b1;
    idex_bubble  = 1'b0;
    ifid_flush   = 1'b0;
    exmem_bubble = 1'b0;
    md_busy      = 1'b0;
    md_done      = 1'b0;
    state_nxt    = state;
    md_cnt_nxt   = md_cnt;

    if (reset) begin
      state_nxt  = RUN;
      md_cnt_nxt = '0;
    end else begin
      case (state)
        RUN: begin
          if (ex_redirect) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
          end else if (ex_md_op && (MD_LAT > 1)) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_write   = 1'b0;
            exmem_bubble = 1'b1;
            md_busy      = 1'b1;
            state_nxt    = MD_BUSY;
            md_cnt_nxt   = MD_LOAD;
          end else begin
            // Single-cycle MD op completes like any other instruction.
            md_done = ex_md_op;
            if (load_use) begin
              pc_write    = 1'b0;
              ifid_write  = 1'b0;
              idex_bubble = 1'b1;
            end
          end
        end
        MD_BUSY: begin
          md_busy = 1'b1;
          if (md_cnt == '0) begin
            md_done   = 1'b1;
            state_nxt = RUN;
          end else begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_write   = 1'b0;
            exmem_bubble = 1'b1;
            md_cnt_nxt   = md_cnt - 1'b1;
          end
        end
        default: begin
          state_nxt  = RUN;
          md_cnt_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= RUN;
      md_cnt <= '0;
    end else begin
      state  <= state_nxt;
      md_cnt <= md_cnt_nxt;
    end
  end

`ifdef STALL_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (!pc_write && (stall_cycles != '1))
        stall_cycles <= stall_cycles + 1'b1;
      if (ifid_flush && (flush_count != '1))
        flush_count <= flush_count + 1'b1;
    end
  end
`endif

endmodule

// File: doc/ex_hazard_ctrl.md
# ex_hazard_ctrl

Pipeline hazard and sequencing controller for the 5-stage RV32 core. It owns stall, bubble and flush decisions around the execute stage: load-use interlock, control-transfer flush on a branch, JAL or JALR redirect resolved in EX, and a multi-cycle hold for long-latency EX operations such as M-extension ops. It sits beside the ID/EX and EX/MEM pipeline registers. It drives their write-enables and bubble controls, as well as PC and IF/ID write-enables. It supersedes the ad-hoc ControlMux hazard signal.

## Interface
Parameters:
- RF_ADDRESS, 5, register-file address width
- MD_LAT, 4, EX cycles consumed by a multi-cycle op (range 1..16)
- CNT_W, 32, performance counter width (used only with the configuration macro)

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset, sampled on rising clk
- id_rs1, id_rs2  in  RF_ADDRESS  source registers of the instruction in ID
- id_uses_rs1, id_uses_rs2  in  1  ID instruction actually reads rs1 / rs2
- idex_rd  in  RF_ADDRESS  destination of the instruction in EX
- idex_memread  in  1  EX instruction is a load
- ex_redirect  in  1  branch taken, jal or jalr resolved in EX this cycle
- ex_md_op  in  1  EX instruction is a multi-cycle op
- pc_write  out  1  PC register enable
- ifid_write  out  1  IF/ID register enable
- idex_write  out  1  ID/EX register enable
- idex_bubble  out  1  load zeroed control (NOP) into ID/EX
- ifid_flush  out  1  invalidate IF/ID
- exmem_bubble  out  1  load NOP into EX/MEM
- md_busy  out  1  multi-cycle op in progress
- md_done  out  1  one-cycle pulse on the final EX cycle of a multi-cycle op
- stall_cycles, flush_count  out  CNT_W  performance counters (present only with the configuration macro)

## Operation
- FSM states: RUN, MD_BUSY. Reset state is RUN. The MD counter is $clog2(MD_LAT+1) bits wide and resets to 0.
- Load-use hazard, evaluated in RUN: idex_memread && idex_rd != 0 && ((id_uses_rs1 && idex_rd == id_rs1) || (id_uses_rs2 && idex_rd == id_rs2)).
- Decision priority in RUN, highest first:
  - ex_redirect: ifid_flush=1 and idex_bubble=1. pc_write=1, ifid_write=1 and idex_write=1 (the PC takes the target). Load-use and ex_md_op are ignored that cycle.
  - ex_md_op with MD_LAT>1: pc_write=0, ifid_write=0, idex_write=0, exmem_bubble=1. Go to MD_BUSY and load the counter with MD_LAT-2.
  - ex_md_op with MD_LAT=1: treated as a normal instruction. md_done=1 in the same cycle and there are no stalls.
  - Load-use hazard: pc_write=0, ifid_write=0, idex_bubble=1 (one bubble). idex_write stays 1.
  - None of the above: all write-enables 1, bubbles and flushes 0.
- MD_BUSY:
  - Holds pc_write=0, ifid_write=0, idex_write=0, exmem_bubble=1 and md_busy=1.
  - The counter decrements by 1 per cycle.
  - When the counter is 0: md_done=1, exmem_bubble=0 (the result enters EX/MEM), all enables are 1, and the next state is RUN.
  - ex_redirect and load-use are ignored in MD_BUSY. The EX instruction is frozen, so neither can be newly valid.
- md_busy=1 only in MD_BUSY, and also in the entry cycle from RUN.

## Timing
- All outputs are Mealy-combinational from the state and the current inputs, so the stall takes effect in the same cycle the hazard is seen. State and counter are registered.
- Load-use costs exactly 1 stall cycle. A redirect costs 2 flushed slots (IF/ID and ID/EX) in 1 cycle.
- A multi-cycle op occupies EX for exactly MD_LAT cycles: 1 entry cycle plus MD_LAT-1 cycles in MD_BUSY. md_done fires in cycle MD_LAT, and the next instruction enters EX in cycle MD_LAT+1.
- Back-to-back multi-cycle ops: after md_done, the next EX instruction is evaluated normally in RUN and re-enters MD_BUSY with no gap cycle.
- While reset=1, outputs take RUN no-hazard values: enables 1, bubbles and flushes 0, md_busy=0, md_done=0. Reset asserted in MD_BUSY returns to RUN on the next edge, the counter clears, and the partial op is abandoned.

## Configuration
- STALL_PERF_CNT_EN defined:
  - stall_cycles increments on every cycle with pc_write=0.
  - flush_count increments on every cycle with ifid_flush=1.
  - Both counters saturate at all-ones and reset synchronously to 0.
- STALL_PERF_CNT_EN undefined: both ports and their counter logic are absent.

## Test plan
- Load-use: lw x5 in EX (idex_memread=1, idex_rd=5), ID add reading rs1=5 with id_uses_rs1=1 -> one cycle of pc_write=0, ifid_write=0, idex_bubble=1, then all enables 1.
- Load to x0, or a matching rs2 with id_uses_rs2=0 -> no stall, idex_bubble=0.
- ex_redirect=1 together with a load-use hazard -> ifid_flush=1, idex_bubble=1, pc_write=1 (redirect wins). flush_count becomes 1 with the macro defined.
- MD_LAT=4 with ex_md_op pulsed -> md_busy=1 for 4 cycles, exmem_bubble=1 for cycles 1–3, md_done=1 only in cycle 4, stall_cycles=3.
- Reset asserted in the 2nd MD_BUSY cycle -> next cycle is in RUN with md_busy=0, md_done never pulses, and all enables are 1.
- MD_LAT=1 with ex_md_op=1 -> md_done=1 in the same cycle and no stall cycles.
